handshake_receiver: RTL and testbench
=====================================

HANDSHAKE_RECEIVER -- requirements
Module: handshake_receiver

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning receive buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter FIRST_VALUE, default 1, meaning first expected sequence value after reset.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port random_stall  input  1  when high, forces ready_o low to model random sink backpressure.
REQ-007 SHALL have port valid_i  input  1  from pre-stage, data_i valid.
REQ-008 SHALL have port data_i  input  DW  from pre-stage, sequence data.
REQ-009 SHALL have port ready_o  output  1  to pre-stage, receiver can accept.
REQ-010 SHALL have port drain_en  input  1  downstream consumer ready; pops buffer head when out_valid high.
REQ-011 SHALL have port out_valid  output  1  buffer non-empty.
REQ-012 SHALL have port out_data  output  DW  buffer head; 0 when out_valid low.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  current buffer occupancy.
REQ-014 SHALL have port rcv_cnt  output  16  accepted-transfer count.
REQ-015 SHALL have port err_o  output  1  sticky sequence-error flag.
REQ-016 SHALL have port err_cnt  output  8  sequence-error count.

Function
REQ-017 SHALL drive ready_o = !full && !random_stall, combinationally; full means level == DEPTH, independent of same-cycle pop.
REQ-018 SHALL treat a transfer as accepted only when valid_i && ready_o at a rising clk edge; data_i ignored otherwise.
REQ-019 SHALL write accepted data into buffer tail; visible on out_data the cycle after acceptance if buffer was empty (1-cycle latency).
REQ-020 SHALL pop head when out_valid && drain_en; push and pop in same cycle leave level unchanged.
REQ-021 SHALL keep an expected-value register exp, reset to FIRST_VALUE, advancing to data_i+1 (mod 2^DW) on every acceptance.
REQ-022 SHALL, on acceptance with data_i != exp, set err_o, increment err_cnt saturating at 255, and resync exp to data_i+1.
REQ-023 SHALL wrap exp from 2^DW-1 to 0 without error (255 followed by 0 is in sequence).
REQ-024 SHALL increment rcv_cnt by 1 per acceptance, wrapping 65535 -> 0.
REQ-025 SHALL never accept when full and never pop when empty; pointers wrap modulo DEPTH.
REQ-026 SHALL hold err_o high until reset; no software clear.

Reset
REQ-027 SHALL, while rst high, force buffer empty (level=0, out_valid=0, out_data=0), rcv_cnt=0, err_cnt=0, err_o=0, exp=FIRST_VALUE.
REQ-028 SHALL drive ready_o low during reset irrespective of random_stall.
REQ-029 SHALL discard buffered data on reset asserted mid-operation; first acceptance after release is checked against FIRST_VALUE.

Structure
REQ-030 SHALL take DW, DEPTH, FIRST_VALUE defaults from shared package handshake_pkg, also used by the sender bench.
REQ-031 SHALL implement the buffer as sub-module sync_fifo (DW, DEPTH; push, pop, full, empty, level, head); checker and counters in top.

Verification
REQ-032 SHALL cover: random_stall=0, drain_en=1, sender sends 1..10 -> 10 acceptances, out_data 1..10 in order, rcv_cnt=10, err_o=0.
REQ-033 SHALL cover: drain_en=0, valid_i held high with 1,2,3,4,5 -> ready_o low after 4th acceptance, level=4, value 5 held until drain_en=1.
REQ-034 SHALL cover: sequence 1,2,4,5 -> err_o=1 at acceptance of 4, err_cnt=1, 5 accepted without further error.
REQ-035 SHALL cover: sequence 254,255,0,1 after exp=254 -> err_cnt unchanged, wrap accepted.
REQ-036 SHALL cover: random_stall toggled randomly, valid_i random, 1000 transfers -> no loss/duplication, rcv_cnt=1000, err_o=0.
REQ-037 SHALL cover: rst pulsed with level=3 -> level=0, out_valid=0, next input 1 accepted without error.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared defaults and counter types for the handshake sender/receiver pair.
package handshake_pkg;

    localparam int unsigned DEF_DW          = 8;
    localparam int unsigned DEF_DEPTH       = 4;
    localparam int unsigned DEF_FIRST_VALUE = 1;

    localparam int unsigned RCV_CNT_W = 16;
    localparam int unsigned ERR_CNT_W = 8;

    typedef logic [RCV_CNT_W-1:0] rcv_cnt_t;
    typedef logic [ERR_CNT_W-1:0] err_cnt_t;

    localparam err_cnt_t ERR_CNT_MAX = '1;

    // Saturating increment for the error counter.
    function automatic err_cnt_t err_cnt_inc(input err_cnt_t c);
        return (c == ERR_CNT_MAX) ? c : c + err_cnt_t'(1);
    endfunction

endpackage

// File: rtl/handshake_receiver_if.sv
// Upstream valid/ready/data channel between a sequence sender and the receiver.
interface handshake_receiver_if
    import handshake_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
);
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;

    modport master (output valid_i, output data_i, input ready_o);
    modport slave  (input valid_i, input data_i, output ready_o);
endinterface

// File: rtl/handshake_receiver_sync_fifo.sv
// Single-clock FIFO with occupancy count; head is the oldest entry.
module sync_fifo
    import handshake_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DW-1:0]            head
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // Guard against overflow/underflow even if the caller does not.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign head  = mem[rptr];

    // Pointer and occupancy tracking; pointers wrap naturally as DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty so it is not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/handshake_receiver.sv
// Sequence receiver: buffers accepted data and checks it forms an incrementing sequence.
module handshake_receiver
    import handshake_pkg::*;
#(
    parameter int unsigned DW          = DEF_DW,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned FIRST_VALUE = DEF_FIRST_VALUE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   random_stall,
    handshake_receiver_if.slave    up,
    input  logic                   drain_en,
    output logic                   out_valid,
    output logic [DW-1:0]          out_data,
    output logic [$clog2(DEPTH):0] level,
    output rcv_cnt_t               rcv_cnt,
    output logic                   err_o,
    output err_cnt_t               err_cnt
);
    logic          full;
    logic          empty;
    logic          accept;
    logic          pop;
    logic [DW-1:0] head;
    logic [DW-1:0] exp_val;

    // Ready ignores a same-cycle pop so the path from drain_en stays out of ready_o.
    assign up.ready_o = !rst && !full && !random_stall;
    assign accept     = up.valid_i && up.ready_o;
    assign out_valid  = !empty;
    assign pop        = out_valid && drain_en;
    assign out_data   = out_valid ? head : '0;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (up.data_i),
        .full  (full),
        .empty (empty),
        .level (level),
        .head  (head)
    );

    // Sequence checker: resync to the received value on every acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_val <= DW'(FIRST_VALUE);
            err_o   <= 1'b0;
            err_cnt <= '0;
            rcv_cnt <= '0;
        end else if (accept) begin
            exp_val <= up.data_i + DW'(1);
            rcv_cnt <= rcv_cnt + rcv_cnt_t'(1);
            if (up.data_i != exp_val) begin
                err_o   <= 1'b1;
                err_cnt <= err_cnt_inc(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_handshake_receiver.sv
// Self-checking bench for handshake_receiver against a queue-based reference model.
module tb_handshake_receiver;
    import handshake_pkg::*;

    localparam int unsigned DW    = DEF_DW;
    localparam int unsigned DEPTH = DEF_DEPTH;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          random_stall;
    logic          drain_en;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [LW-1:0] level;
    logic [15:0]   rcv_cnt;
    logic          err_o;
    logic [7:0]    err_cnt;

    handshake_receiver_if #(.DW(DW)) hs ();

    handshake_receiver #(
        .DW          (DW),
        .DEPTH       (DEPTH),
        .FIRST_VALUE (DEF_FIRST_VALUE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .random_stall (random_stall),
        .up           (hs.slave),
        .drain_en     (drain_en),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .level        (level),
        .rcv_cnt      (rcv_cnt),
        .err_o        (err_o),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: buffer contents, counters and expected next value.
    logic [DW-1:0] mq[$];
    int            m_rcv;
    int            m_err_cnt;
    bit            m_err;
    int            m_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rcv     = 0;
        m_err_cnt = 0;
        m_err     = 0;
        m_exp     = DEF_FIRST_VALUE % (1 << DW);
    endtask

    // One clock cycle: compare outputs against the model, then advance the model.
    task automatic cycle(output bit acc);
        bit            m_ready;
        bit            dpop;
        logic [DW-1:0] d;
        #1;
        m_ready = (mq.size() < DEPTH) && !random_stall;
        check("ready_o", hs.ready_o, m_ready);
        check("out_valid", out_valid, mq.size() != 0);
        check("out_data", out_data, (mq.size() != 0) ? mq[0] : 0);
        check("level", level, mq.size());
        check("rcv_cnt", rcv_cnt, m_rcv);
        check("err_o", err_o, m_err);
        check("err_cnt", err_cnt, m_err_cnt);
        acc  = hs.valid_i && m_ready;
        dpop = drain_en && (mq.size() != 0);
        d    = hs.data_i;
        @(posedge clk);
        if (dpop) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(d);
            m_rcv = (m_rcv + 1) % 65536;
            if (int'(d) != m_exp) begin
                m_err = 1;
                if (m_err_cnt < 255) m_err_cnt++;
            end
            m_exp = (int'(d) + 1) % (1 << DW);
        end
        @(negedge clk);
    endtask

    // Present one value and hold it until the model says it was accepted.
    task automatic send(input logic [DW-1:0] v);
        bit acc;
        acc        = 0;
        hs.valid_i = 1'b1;
        hs.data_i  = v;
        for (int n = 0; n < 200 && !acc; n++) cycle(acc);
        check("send_accepted", acc, 1);
        hs.valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        random_stall = 1'b0;
        drain_en     = 1'b0;
        hs.valid_i   = 1'b0;
        hs.data_i    = '0;
        #1;
        check("rst_ready_low", hs.ready_o, 0);
        @(negedge clk);
        #1;
        check("rst_level", level, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_rcv_cnt", rcv_cnt, 0);
        check("rst_err_o", err_o, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_ready_low_2", hs.ready_o, 0);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] val;
        bit            acc;
        int            guard;

        do_reset();

        // In-order stream with the sink always draining.
        drain_en = 1'b1;
        for (int i = 1; i <= 10; i++) send(DW'(i));
        idle(3);
        check("s1_rcv_cnt", rcv_cnt, 10);
        check("s1_err_o", err_o, 0);

        // Fill the buffer with no drain; ready must drop after four acceptances.
        do_reset();
        for (int i = 1; i <= 4; i++) send(DW'(i));
        hs.valid_i = 1'b1;
        hs.data_i  = DW'(5);
        idle(3);
        check("s2_full_ready", hs.ready_o, 0);
        check("s2_full_level", level, DEPTH);
        check("s2_head_held", out_data, 1);
        drain_en = 1'b1;
        send(DW'(5));
        idle(6);
        check("s2_rcv_cnt", rcv_cnt, 5);
        check("s2_level_drained", level, 0);

        // Gap in the sequence flags one error, then resyncs.
        do_reset();
        drain_en = 1'b1;
        send(DW'(1));
        send(DW'(2));
        send(DW'(4));
        check("s3_err_o", err_o, 1);
        check("s3_err_cnt", err_cnt, 1);
        send(DW'(5));
        check("s3_err_cnt_after5", err_cnt, 1);

        // Resync to 254 and then wrap through 255 -> 0 without error.
        send(DW'(253));
        check("s4_err_cnt_resync", err_cnt, 2);
        send(DW'(254));
        send(DW'(255));
        send(DW'(0));
        send(DW'(1));
        check("s4_err_cnt_wrap", err_cnt, 2);
        check("s4_err_sticky", err_o, 1);

        // Randomised valid, stall and drain over 1000 transfers.
        do_reset();
        val   = DW'(DEF_FIRST_VALUE);
        guard = 0;
        while (m_rcv < 1000 && guard < 20000) begin
            random_stall = 1'($urandom_range(0, 1));
            drain_en     = ($urandom_range(0, 3) != 0);
            hs.valid_i   = 1'($urandom_range(0, 1));
            hs.data_i    = val;
            cycle(acc);
            if (acc) val = val + DW'(1);
            guard++;
        end
        check("s5_budget", m_rcv, 1000);
        hs.valid_i   = 1'b0;
        random_stall = 1'b0;
        drain_en     = 1'b1;
        idle(DEPTH + 2);
        check("s5_rcv_cnt", rcv_cnt, 1000);
        check("s5_err_o", err_o, 0);
        check("s5_level", level, 0);

        // Asynchronous reset mid-operation with three entries buffered.
        do_reset();
        send(DW'(1));
        send(DW'(2));
        send(DW'(3));
        check("s6_level3", level, 3);
        #2;
        rst = 1'b1;
        #1;
        check("s6_async_level", level, 0);
        check("s6_async_out_valid", out_valid, 0);
        check("s6_async_out_data", out_data, 0);
        check("s6_async_ready", hs.ready_o, 0);
        check("s6_async_rcv_cnt", rcv_cnt, 0);
        model_reset();
        @(negedge clk);
        rst      = 1'b0;
        drain_en = 1'b1;
        send(DW'(1));
        check("s6_err_o", err_o, 0);
        check("s6_err_cnt", err_cnt, 0);
        check("s6_rcv_cnt", rcv_cnt, 1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
